// File: rtl/tl_ul_arbiter_2to1.sv
// rtl/tl_ul_arbiter_2to1.sv - two-client round-robin TL-UL arbiter with burst lock and D-channel demux
//
// Purpose
//   Shares one TL-UL manager port between two client ports. The A channel is arbitrated
//   round-robin. A multi-beat Put burst is locked to the client that owns it. The D channel
//   is demuxed back to a client by the MSB of the returned source.
//
// Ports
//   clock, reset                : single clock, synchronous active-high reset
//   auto_in{0,1}_a_*            : client A channels (source SRC_W bits)
//   auto_in{0,1}_d_*            : client D channels (source SRC_W bits)
//   auto_out_a_*                : manager A channel (source SRC_W+1 bits, MSB = client index)
//   auto_out_d_*                : manager D channel (source SRC_W+1 bits)
//   grant_cnt0, grant_cnt1      : 16-bit first-beat grant counters, present only with TL_ARB_PERF_EN
//
// Optional feature macro: TL_ARB_PERF_EN
module tl_ul_arbiter_2to1 #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int SRC_W    = 5,
    parameter int MAX_SIZE = 6
) (
    input  logic                clock,
    input  logic                reset,
    // client 0 A
    input  logic                auto_in0_a_valid,
    output logic                auto_in0_a_ready,
    input  logic [2:0]          auto_in0_a_bits_opcode,
    input  logic [2:0]          auto_in0_a_bits_param,
    input  logic [3:0]          auto_in0_a_bits_size,
    input  logic [SRC_W-1:0]    auto_in0_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in0_a_bits_address,
    input  logic [DATA_W/8-1:0] auto_in0_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in0_a_bits_data,
    input  logic                auto_in0_a_bits_corrupt,
    // client 0 D
    output logic                auto_in0_d_valid,
    input  logic                auto_in0_d_ready,
    output logic [2:0]          auto_in0_d_bits_opcode,
    output logic [1:0]          auto_in0_d_bits_param,
    output logic [3:0]          auto_in0_d_bits_size,
    output logic [SRC_W-1:0]    auto_in0_d_bits_source,
    output logic                auto_in0_d_bits_sink,
    output logic                auto_in0_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in0_d_bits_data,
    output logic                auto_in0_d_bits_corrupt,
    // client 1 A
    input  logic                auto_in1_a_valid,
    output logic                auto_in1_a_ready,
    input  logic [2:0]          auto_in1_a_bits_opcode,
    input  logic [2:0]          auto_in1_a_bits_param,
    input  logic [3:0]          auto_in1_a_bits_size,
    input  logic [SRC_W-1:0]    auto_in1_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in1_a_bits_address,
    input  logic [DATA_W/8-1:0] auto_in1_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in1_a_bits_data,
    input  logic                auto_in1_a_bits_corrupt,
    // client 1 D
    output logic                auto_in1_d_valid,
    input  logic                auto_in1_d_ready,
    output logic [2:0]          auto_in1_d_bits_opcode,
    output logic [1:0]          auto_in1_d_bits_param,
    output logic [3:0]          auto_in1_d_bits_size,
    output logic [SRC_W-1:0]    auto_in1_d_bits_source,
    output logic                auto_in1_d_bits_sink,
    output logic                auto_in1_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in1_d_bits_data,
    output logic                auto_in1_d_bits_corrupt,
    // manager A
    output logic                auto_out_a_valid,
    input  logic                auto_out_a_ready,
    output logic [2:0]          auto_out_a_bits_opcode,
    output logic [2:0]          auto_out_a_bits_param,
    output logic [3:0]          auto_out_a_bits_size,
    output logic [SRC_W:0]      auto_out_a_bits_source,
    output logic [ADDR_W-1:0]   auto_out_a_bits_address,
    output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
    output logic [DATA_W-1:0]   auto_out_a_bits_data,
    output logic                auto_out_a_bits_corrupt,
    // manager D
    input  logic                auto_out_d_valid,
    output logic                auto_out_d_ready,
    input  logic [2:0]          auto_out_d_bits_opcode,
    input  logic [1:0]          auto_out_d_bits_param,
    input  logic [3:0]          auto_out_d_bits_size,
    input  logic [SRC_W:0]      auto_out_d_bits_source,
    input  logic                auto_out_d_bits_sink,
    input  logic                auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]   auto_out_d_bits_data,
    input  logic                auto_out_d_bits_corrupt
`ifdef TL_ARB_PERF_EN
    ,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1
`endif
);

    localparam int LG_BEAT = $clog2(DATA_W / 8);
    // Wide enough to hold the beat count of the largest legal burst.
    localparam int CNT_W   = MAX_SIZE - LG_BEAT + 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BURST} state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_rr_last;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_sel;
    logic             w_sel_valid;
    logic             w_a_fire;
    logic             w_is_put;
    logic [3:0]       w_eff_size;
    logic [CNT_W-1:0] w_beats_m1;
    logic             w_d_sel;

    // Only IDLE arbitrates; HOLD and BURST keep the registered owner so the grant cannot move.
    always_comb begin
        w_sel = r_owner;
        if (r_state == S_IDLE) begin
            if (auto_in0_a_valid && auto_in1_a_valid) begin
                w_sel = ~r_rr_last;
            end else begin
                w_sel = auto_in1_a_valid;
            end
        end
    end

    assign w_sel_valid      = w_sel ? auto_in1_a_valid : auto_in0_a_valid;
    assign auto_out_a_valid = ~reset & w_sel_valid;
    assign auto_in0_a_ready = ~reset & ~w_sel & auto_out_a_ready;
    assign auto_in1_a_ready = ~reset &  w_sel & auto_out_a_ready;
    assign w_a_fire         = auto_out_a_valid & auto_out_a_ready;

    assign auto_out_a_bits_opcode  = w_sel ? auto_in1_a_bits_opcode  : auto_in0_a_bits_opcode;
    assign auto_out_a_bits_param   = w_sel ? auto_in1_a_bits_param   : auto_in0_a_bits_param;
    assign auto_out_a_bits_size    = w_sel ? auto_in1_a_bits_size    : auto_in0_a_bits_size;
    assign auto_out_a_bits_source  = {w_sel, (w_sel ? auto_in1_a_bits_source : auto_in0_a_bits_source)};
    assign auto_out_a_bits_address = w_sel ? auto_in1_a_bits_address : auto_in0_a_bits_address;
    assign auto_out_a_bits_mask    = w_sel ? auto_in1_a_bits_mask    : auto_in0_a_bits_mask;
    assign auto_out_a_bits_data    = w_sel ? auto_in1_a_bits_data    : auto_in0_a_bits_data;
    assign auto_out_a_bits_corrupt = w_sel ? auto_in1_a_bits_corrupt : auto_in0_a_bits_corrupt;

    // Beats minus one for the selected message; oversize requests saturate at MAX_SIZE.
    assign w_is_put   = (auto_out_a_bits_opcode[2:1] == 2'b00);
    assign w_eff_size = (auto_out_a_bits_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : auto_out_a_bits_size;
    always_comb begin
        w_beats_m1 = '0;
        if (w_is_put && (w_eff_size > 4'(LG_BEAT))) begin
            w_beats_m1 = (CNT_W'(1) << (w_eff_size - 4'(LG_BEAT))) - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_rr_last  <= 1'b1;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_a_fire) begin
                        r_rr_last <= w_sel;
                        if (w_beats_m1 != '0) begin
                            r_state    <= S_BURST;
                            r_owner    <= w_sel;
                            r_beat_cnt <= w_beats_m1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if ((r_state == S_IDLE) && auto_out_a_valid) begin
                        r_state <= S_HOLD;
                        r_owner <= w_sel;
                    end
                end
                S_BURST: begin
                    if (w_a_fire) begin
                        r_beat_cnt <= r_beat_cnt - CNT_W'(1);
                        if (r_beat_cnt == CNT_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // D channel: route by the client-index bit carried in the source MSB.
    assign w_d_sel          = auto_out_d_bits_source[SRC_W];
    assign auto_in0_d_valid = ~reset & auto_out_d_valid & ~w_d_sel;
    assign auto_in1_d_valid = ~reset & auto_out_d_valid &  w_d_sel;
    assign auto_out_d_ready = ~reset & (w_d_sel ? auto_in1_d_ready : auto_in0_d_ready);

    assign auto_in0_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in0_d_bits_param   = auto_out_d_bits_param;
    assign auto_in0_d_bits_size    = auto_out_d_bits_size;
    assign auto_in0_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in0_d_bits_sink    = auto_out_d_bits_sink;
    assign auto_in0_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in0_d_bits_data    = auto_out_d_bits_data;
    assign auto_in0_d_bits_corrupt = auto_out_d_bits_corrupt;
    assign auto_in1_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in1_d_bits_param   = auto_out_d_bits_param;
    assign auto_in1_d_bits_size    = auto_out_d_bits_size;
    assign auto_in1_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in1_d_bits_sink    = auto_out_d_bits_sink;
    assign auto_in1_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in1_d_bits_data    = auto_out_d_bits_data;
    assign auto_in1_d_bits_corrupt = auto_out_d_bits_corrupt;

`ifdef TL_ARB_PERF_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    // A fire outside BURST is always the first beat of a message.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else if (w_a_fire && (r_state != S_BURST)) begin
            if (w_sel) begin
                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            end else begin
                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            end
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// tb/tb_tl_ul_arbiter_2to1.sv - directed self-checking bench for tl_ul_arbiter_2to1
module tb_tl_ul_arbiter_2to1;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 5;

    localparam logic [2:0] OP_PUTFULL = 3'd0;
    localparam logic [2:0] OP_GET     = 3'd4;

    logic clock = 1'b0;
    logic reset;

    logic                in0_a_valid, in0_a_ready;
    logic [2:0]          in0_a_opcode, in0_a_param;
    logic [3:0]          in0_a_size;
    logic [SRC_W-1:0]    in0_a_source;
    logic [ADDR_W-1:0]   in0_a_address;
    logic [DATA_W/8-1:0] in0_a_mask;
    logic [DATA_W-1:0]   in0_a_data;
    logic                in0_a_corrupt;
    logic                in0_d_valid, in0_d_ready;
    logic [2:0]          in0_d_opcode;
    logic [1:0]          in0_d_param;
    logic [3:0]          in0_d_size;
    logic [SRC_W-1:0]    in0_d_source;
    logic                in0_d_sink, in0_d_denied, in0_d_corrupt;
    logic [DATA_W-1:0]   in0_d_data;

    logic                in1_a_valid, in1_a_ready;
    logic [2:0]          in1_a_opcode, in1_a_param;
    logic [3:0]          in1_a_size;
    logic [SRC_W-1:0]    in1_a_source;
    logic [ADDR_W-1:0]   in1_a_address;
    logic [DATA_W/8-1:0] in1_a_mask;
    logic [DATA_W-1:0]   in1_a_data;
    logic                in1_a_corrupt;
    logic                in1_d_valid, in1_d_ready;
    logic [2:0]          in1_d_opcode;
    logic [1:0]          in1_d_param;
    logic [3:0]          in1_d_size;
    logic [SRC_W-1:0]    in1_d_source;
    logic                in1_d_sink, in1_d_denied, in1_d_corrupt;
    logic [DATA_W-1:0]   in1_d_data;

    logic                out_a_valid, out_a_ready;
    logic [2:0]          out_a_opcode, out_a_param;
    logic [3:0]          out_a_size;
    logic [SRC_W:0]      out_a_source;
    logic [ADDR_W-1:0]   out_a_address;
    logic [DATA_W/8-1:0] out_a_mask;
    logic [DATA_W-1:0]   out_a_data;
    logic                out_a_corrupt;
    logic                out_d_valid, out_d_ready;
    logic [2:0]          out_d_opcode;
    logic [1:0]          out_d_param;
    logic [3:0]          out_d_size;
    logic [SRC_W:0]      out_d_source;
    logic                out_d_sink, out_d_denied, out_d_corrupt;
    logic [DATA_W-1:0]   out_d_data;
`ifdef TL_ARB_PERF_EN
    logic [15:0]         grant_cnt0, grant_cnt1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    tl_ul_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .MAX_SIZE(6)) dut (
        .clock(clock), .reset(reset),
        .auto_in0_a_valid(in0_a_valid), .auto_in0_a_ready(in0_a_ready),
        .auto_in0_a_bits_opcode(in0_a_opcode), .auto_in0_a_bits_param(in0_a_param),
        .auto_in0_a_bits_size(in0_a_size), .auto_in0_a_bits_source(in0_a_source),
        .auto_in0_a_bits_address(in0_a_address), .auto_in0_a_bits_mask(in0_a_mask),
        .auto_in0_a_bits_data(in0_a_data), .auto_in0_a_bits_corrupt(in0_a_corrupt),
        .auto_in0_d_valid(in0_d_valid), .auto_in0_d_ready(in0_d_ready),
        .auto_in0_d_bits_opcode(in0_d_opcode), .auto_in0_d_bits_param(in0_d_param),
        .auto_in0_d_bits_size(in0_d_size), .auto_in0_d_bits_source(in0_d_source),
        .auto_in0_d_bits_sink(in0_d_sink), .auto_in0_d_bits_denied(in0_d_denied),
        .auto_in0_d_bits_data(in0_d_data), .auto_in0_d_bits_corrupt(in0_d_corrupt),
        .auto_in1_a_valid(in1_a_valid), .auto_in1_a_ready(in1_a_ready),
        .auto_in1_a_bits_opcode(in1_a_opcode), .auto_in1_a_bits_param(in1_a_param),
        .auto_in1_a_bits_size(in1_a_size), .auto_in1_a_bits_source(in1_a_source),
        .auto_in1_a_bits_address(in1_a_address), .auto_in1_a_bits_mask(in1_a_mask),
        .auto_in1_a_bits_data(in1_a_data), .auto_in1_a_bits_corrupt(in1_a_corrupt),
        .auto_in1_d_valid(in1_d_valid), .auto_in1_d_ready(in1_d_ready),
        .auto_in1_d_bits_opcode(in1_d_opcode), .auto_in1_d_bits_param(in1_d_param),
        .auto_in1_d_bits_size(in1_d_size), .auto_in1_d_bits_source(in1_d_source),
        .auto_in1_d_bits_sink(in1_d_sink), .auto_in1_d_bits_denied(in1_d_denied),
        .auto_in1_d_bits_data(in1_d_data), .auto_in1_d_bits_corrupt(in1_d_corrupt),
        .auto_out_a_valid(out_a_valid), .auto_out_a_ready(out_a_ready),
        .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
        .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
        .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
        .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
        .auto_out_d_valid(out_d_valid), .auto_out_d_ready(out_d_ready),
        .auto_out_d_bits_opcode(out_d_opcode), .auto_out_d_bits_param(out_d_param),
        .auto_out_d_bits_size(out_d_size), .auto_out_d_bits_source(out_d_source),
        .auto_out_d_bits_sink(out_d_sink), .auto_out_d_bits_denied(out_d_denied),
        .auto_out_d_bits_data(out_d_data), .auto_out_d_bits_corrupt(out_d_corrupt)
`ifdef TL_ARB_PERF_EN
        ,
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a0(input logic v, input logic [2:0] op, input logic [3:0] sz,
                          input logic [SRC_W-1:0] src, input logic [DATA_W-1:0] dat);
        in0_a_valid = v; in0_a_opcode = op; in0_a_size = sz; in0_a_source = src; in0_a_data = dat;
    endtask

    task automatic set_a1(input logic v, input logic [2:0] op, input logic [3:0] sz,
                          input logic [SRC_W-1:0] src, input logic [DATA_W-1:0] dat);
        in1_a_valid = v; in1_a_opcode = op; in1_a_size = sz; in1_a_source = src; in1_a_data = dat;
    endtask

    initial begin
        logic [5:0] rdy_pat;
        logic [DATA_W-1:0] beat;

        reset = 1'b1;
        set_a0(1'b0, OP_GET, 4'd2, '0, '0);
        set_a1(1'b0, OP_GET, 4'd2, '0, '0);
        in0_a_param = '0; in0_a_address = '0; in0_a_mask = 4'hF; in0_a_corrupt = 1'b0;
        in1_a_param = '0; in1_a_address = '0; in1_a_mask = 4'hF; in1_a_corrupt = 1'b0;
        in0_d_ready = 1'b0; in1_d_ready = 1'b0; out_a_ready = 1'b0;
        out_d_valid = 1'b0; out_d_opcode = 3'd1; out_d_param = '0; out_d_size = 4'd2;
        out_d_source = '0; out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_data = '0; out_d_corrupt = 1'b0;
        tick();
        tick();

        // Outputs held quiet while reset is high, even with upstream activity.
        in0_a_valid = 1'b1; out_a_ready = 1'b1; out_d_valid = 1'b1; in0_d_ready = 1'b1;
        #1;
        chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
        chk("rst_in0_a_ready", 64'(in0_a_ready), 64'd0);
        chk("rst_in0_d_valid", 64'(in0_d_valid), 64'd0);
        chk("rst_out_d_ready", 64'(out_d_ready), 64'd0);
        tick();
        reset = 1'b0;
        in0_a_valid = 1'b0; out_d_valid = 1'b0;

        // Single Get on in0, same-cycle forwarding.
        set_a0(1'b1, OP_GET, 4'd2, 5'd3, 32'h0);
        in0_a_address = 28'h1234560;
        #1;
        chk("get_out_a_valid", 64'(out_a_valid), 64'd1);
        chk("get_out_a_source", 64'(out_a_source), 64'h03);
        chk("get_in0_a_ready", 64'(in0_a_ready), 64'd1);
        chk("get_in1_a_ready", 64'(in1_a_ready), 64'd0);
        chk("get_out_a_address", 64'(out_a_address), 64'h1234560);
        tick();
        in0_a_valid = 1'b0;

        // D demux to in0, then to in1 with back-pressure.
        out_d_valid = 1'b1; out_d_source = 6'h03; out_d_data = 32'hDEADBEEF;
        in0_d_ready = 1'b1; in1_d_ready = 1'b1;
        #1;
        chk("d0_in0_d_valid", 64'(in0_d_valid), 64'd1);
        chk("d0_in1_d_valid", 64'(in1_d_valid), 64'd0);
        chk("d0_in0_d_source", 64'(in0_d_source), 64'h03);
        chk("d0_in0_d_data", 64'(in0_d_data), 64'hDEADBEEF);
        chk("d0_out_d_ready", 64'(out_d_ready), 64'd1);
        out_d_source = 6'h25; in1_d_ready = 1'b0;
        #1;
        chk("d1_in1_d_valid", 64'(in1_d_valid), 64'd1);
        chk("d1_in0_d_valid", 64'(in0_d_valid), 64'd0);
        chk("d1_in1_d_source", 64'(in1_d_source), 64'h05);
        chk("d1_out_d_ready", 64'(out_d_ready), 64'd0);
        tick();
        out_d_valid = 1'b0;

        // Both clients request every cycle: 0,1,0,1 after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_a0(1'b1, OP_GET, 4'd2, 5'd1, '0);
        set_a1(1'b1, OP_GET, 4'd2, 5'd2, '0);
        out_a_ready = 1'b1;
        #1; chk("rr_grant0", 64'(out_a_source), 64'h01); tick();
        #1; chk("rr_grant1", 64'(out_a_source), 64'h22); tick();
        #1; chk("rr_grant2", 64'(out_a_source), 64'h01); tick();
        #1; chk("rr_grant3", 64'(out_a_source), 64'h22); tick();
        in0_a_valid = 1'b0; in1_a_valid = 1'b0;

        // in1 4-beat PutFull, acquired via HOLD, in0 waiting throughout.
        set_a1(1'b1, OP_PUTFULL, 4'd4, 5'd7, 32'd0);
        out_a_ready = 1'b0;
        #1;
        chk("burst_hold_valid", 64'(out_a_valid), 64'd1);
        chk("burst_hold_source", 64'(out_a_source), 64'h27);
        tick();
        set_a0(1'b1, OP_GET, 4'd2, 5'd9, '0);
        rdy_pat = 6'b110101;  // bit j is out_a_ready in step j: 1,0,1,0,1,1
        beat = 32'd0;
        for (int j = 0; j < 6; j++) begin
            out_a_ready = rdy_pat[j];
            in1_a_data  = beat;
            #1;
            chk("burst_in1_a_ready", 64'(in1_a_ready), 64'(rdy_pat[j]));
            chk("burst_in0_a_ready", 64'(in0_a_ready), 64'd0);
            chk("burst_source", 64'(out_a_source), 64'h27);
            chk("burst_data", 64'(out_a_data), 64'(beat));
            tick();
            if (rdy_pat[j]) beat = beat + 32'd1;
        end
        set_a1(1'b1, OP_GET, 4'd2, 5'd8, '0);
        out_a_ready = 1'b1;
        #1;
        chk("after_burst_in0_a_ready", 64'(in0_a_ready), 64'd1);
        chk("after_burst_source", 64'(out_a_source), 64'h09);
        tick();
        in1_a_valid = 1'b0;

        // HOLD: in0 stalls 3 cycles, in1 arrives in cycle 2 and must wait.
        set_a0(1'b1, OP_GET, 4'd2, 5'd4, '0);
        out_a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_a1(1'b1, OP_GET, 4'd2, 5'd6, '0);
            #1;
            chk("hold_source", 64'(out_a_source), 64'h04);
            chk("hold_in1_a_ready", 64'(in1_a_ready), 64'd0);
            tick();
        end
        out_a_ready = 1'b1;
        #1;
        chk("hold_fire_in0_a_ready", 64'(in0_a_ready), 64'd1);
        tick();
        in0_a_valid = 1'b0;
        #1;
        chk("hold_next_source", 64'(out_a_source), 64'h26);
        chk("hold_next_in1_a_ready", 64'(in1_a_ready), 64'd1);
        tick();
        in1_a_valid = 1'b0;

        // Oversize PutFull (size 8) saturates to 16 beats.
        set_a1(1'b1, OP_PUTFULL, 4'd8, 5'd1, '0);
        #1;
        chk("big_first_in1_a_ready", 64'(in1_a_ready), 64'd1);
        tick();
        set_a0(1'b1, OP_GET, 4'd2, 5'd2, '0);
        for (int b = 0; b < 15; b++) begin
            #1;
            chk("big_in0_a_ready", 64'(in0_a_ready), 64'd0);
            chk("big_in1_a_ready", 64'(in1_a_ready), 64'd1);
            tick();
        end
        #1;
        chk("big_after_in0_a_ready", 64'(in0_a_ready), 64'd1);
        chk("big_after_source", 64'(out_a_source), 64'h02);
        tick();
        in0_a_valid = 1'b0; in1_a_valid = 1'b0;

        // PutFull of exactly one beat (size 2) is a single-beat message.
        set_a1(1'b1, OP_PUTFULL, 4'd2, 5'd3, '0);
        tick();
        in1_a_valid = 1'b0;
        set_a0(1'b1, OP_GET, 4'd2, 5'd5, '0);
        #1;
        chk("onebeat_in0_a_ready", 64'(in0_a_ready), 64'd1);
        tick();
        in0_a_valid = 1'b0;

        // Reset in the middle of an 8-beat burst.
        set_a0(1'b1, OP_PUTFULL, 4'd5, 5'd3, '0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rstb_out_a_valid", 64'(out_a_valid), 64'd0);
        chk("rstb_in0_a_ready", 64'(in0_a_ready), 64'd0);
        tick();
        reset = 1'b0;
        in0_a_valid = 1'b0;
        set_a1(1'b1, OP_GET, 4'd2, 5'd5, '0);
        #1;
        chk("rstb_in1_valid", 64'(out_a_valid), 64'd1);
        chk("rstb_in1_source", 64'(out_a_source), 64'h25);
        chk("rstb_in1_a_ready", 64'(in1_a_ready), 64'd1);
        tick();
        in1_a_valid = 1'b0;
        set_a0(1'b1, OP_GET, 4'd2, 5'd1, '0);
        #1;
        chk("rstb_in0_a_ready", 64'(in0_a_ready), 64'd1);
        chk("rstb_in0_source", 64'(out_a_source), 64'h01);
        tick();
        in0_a_valid = 1'b0;

`ifdef TL_ARB_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("perf_rst_cnt0", 64'(grant_cnt0), 64'd0);
        chk("perf_rst_cnt1", 64'(grant_cnt1), 64'd0);
        set_a0(1'b1, OP_GET, 4'd2, 5'd1, '0);
        repeat (3) tick();
        in0_a_valid = 1'b0;
        set_a1(1'b1, OP_GET, 4'd2, 5'd1, '0);
        repeat (5) tick();
        in1_a_valid = 1'b0;
        #1;
        chk("perf_cnt0", 64'(grant_cnt0), 64'd3);
        chk("perf_cnt1", 64'(grant_cnt1), 64'd5);
        reset = 1'b1;
        tick();
        #1;
        chk("perf_clr_cnt0", 64'(grant_cnt0), 64'd0);
        chk("perf_clr_cnt1", 64'(grant_cnt1), 64'd0);
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
